ysyx_25040111_refill_bridge: RTL and testbench
==============================================

// Module: ysyx_25040111_refill_bridge
// PURPOSE
//  Responder end of the cache refill handshake (rstart/rlen/addr in, rok/rdata beats out).
//  Turns one refill request into AXI4 INCR read bursts toward memory.
//  Returns each beat to the requester as a one-cycle rok pulse.
//  Sits between the instruction cache and the system AXI4 crossbar.
//  Splits any request that crosses a 4 KiB page into two bursts.
// PARAMETERS
//  AXI_ID    4'h0  ARID driven on every burst
//  PAGE_Ls   12    log2 of the page size used for the burst-split rule
// PORTS
//  clock      in   1   sole clock; all logic on rising edge
//  reset      in   1   asynchronous, active-low reset
//  rstart     in   1   one-cycle request pulse from the cache
//  addr       in   32  refill start address; bits [1:0] are ignored (word aligned)
//  rlen       in   8   number of 32-bit beats requested; 0 is treated as 1
//  rok        out  1   one-cycle pulse: rdata holds a valid beat
//  rdata      out  32  beat data; held until the next rok
//  rerr       out  1   high with rok when that beat's RRESP was SLVERR or DECERR
//  busy       out  1   high from the cycle after an accepted rstart until the last rok
//  arvalid/arready        out/in  1   AXI read-address handshake
//  araddr     out  32  burst start address, bits [1:0] = 0
//  arid/arlen out  4/8 arid = AXI_ID; arlen = beats-1
//  arsize/arburst  out 3/2  fixed 3'b010 / 2'b01 (INCR)
//  rvalid     in   1   AXI read-data valid
//  rready     out  1   AXI read-data ready
//  axi_rdata  in   32  AXI read data
//  rresp      in   2   AXI read response
//  rlast      in   1   AXI last beat
//  rid        in   4   AXI read ID
// BEHAVIOUR
//  Reset values: rok=0, rdata=0, rerr=0, busy=0, arvalid=0, rready=0, araddr=0, arlen=0.
//  Reset acts asynchronously. Asserting reset mid-burst drops to IDLE at once and
//    abandons the outstanding AXI transaction; the whole system resets together.
//  FSM states: IDLE -> ADDR -> DATA -> (ADDR | IDLE).
//  IDLE
//    - On rstart: latch addr & ~3 and the effective length L.
//    - Compute room = (2^PAGE_Ls - addr[PAGE_Ls-1:0]) >> 2.
//    - First burst length b1 = min(L, room); remaining = L - b1. Go to ADDR.
//  ADDR
//    - arvalid=1, araddr=current address, arlen=b-1.
//    - arvalid and all AR fields stay stable until arready (AXI rule).
//    - On the handshake go to DATA.
//  DATA
//    - rready=1 for the whole state; the requester cannot back-pressure.
//    - Each rvalid&rready: rdata<=axi_rdata, rok<=1 the next cycle (1-cycle latency),
//      rerr<=rresp[1].
//    - Local beat counter decrements each beat.
//    - At counter==0: if remaining>0, set address=next page base and b=remaining,
//      go to ADDR; otherwise go to IDLE.
//  rok is a pulse. It is never high on two consecutive cycles unless AXI returns
//    back-to-back beats.
//  rstart while busy or not in IDLE: ignored, no queueing. The requester must wait for busy=0.
//  The cycle rstart is accepted, busy stays 0; busy=1 from the next cycle.
//  busy falls in the same cycle as the final rok.
//  rlast and rid are not used for control. Simulation-only checks flag:
//    - rlast not coinciding with counter==0;
//    - rid != AXI_ID.
//  An error response does not abort the burst; every beat is still delivered.
//  Minimum latency, rstart to first rok: 3 cycles with arready=1 and a 1-cycle AXI slave.
// STRUCTURE
//  Shared package ysyx_25040111_axi_pkg holds:
//    - AXI_BURST_INCR, AXI_SIZE_4B, RESP_OKAY/EXOKAY/SLVERR/DECERR;
//    - the refill_state_t enum {IDLE, ADDR, DATA};
//    - the function page_room(addr, PAGE_Ls).
//  No sub-module; a single always_ff FSM plus a datapath register set.
// TESTING
//  1 rstart, addr=0x8000_0010, rlen=1, arready=1, slave returns 0xDEADBEEF
//    -> araddr=0x8000_0010, arlen=0; one rok, rdata=0xDEADBEEF, rerr=0.
//  2 rlen=4 at 0x8000_0100, slave inserts 2 idle cycles between beats
//    -> a single burst with arlen=3; 4 rok pulses carrying data in order.
//  3 rlen=4 at 0x8000_0FF8
//    -> burst 1: araddr=0x8000_0FF8, arlen=1.
//    -> burst 2: araddr=0x8000_1000, arlen=1.
//    -> 4 rok total; busy stays continuously high.
//  4 arready held low for 5 cycles
//    -> arvalid, araddr and arlen stay stable for all 5 cycles; no rok before the handshake.
//  5 rlen=2, beat 2 returns rresp=2'b10 -> second rok has rerr=1 and the FSM returns to IDLE.
//  6 reset asserted mid-DATA, asynchronously between clock edges
//    -> all outputs go to their reset values at once.
//    -> after reset release, a new rstart completes normally.
//  7 rlen=0 -> treated as 1 beat, arlen=0.
//  8 A second rstart while busy is ignored: no extra AR is issued.

Source files
------------

// File: rtl/ysyx_25040111_axi_pkg.sv
// Shared AXI4 constants and refill-bridge types.
// The page helper sizes a burst so that it never crosses a page boundary.
package ysyx_25040111_axi_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } refill_state_t;

    // Number of 32-bit words from a word-aligned addr up to the end of its page.
    function automatic logic [31:0] page_room(input logic [31:0] addr, input int page_ls);
        logic [31:0] page_size;
        page_size = 32'd1 << page_ls;
        return (page_size - (addr & (page_size - 32'd1))) >> 2;
    endfunction

endpackage

// File: rtl/ysyx_25040111_refill_bridge.sv
// Cache refill responder: converts one rstart/rlen/addr request into one or two
// AXI4 INCR read bursts (split at page boundaries) and returns beats as rok pulses.
module ysyx_25040111_refill_bridge
    import ysyx_25040111_axi_pkg::*;
#(
    parameter logic [3:0] AXI_ID  = 4'h0,
    parameter int         PAGE_Ls = 12
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rstart,
    input  logic [31:0] addr,
    input  logic [7:0]  rlen,
    output logic        rok,
    output logic [31:0] rdata,
    output logic        rerr,
    output logic        busy,
    output logic        arvalid,
    input  logic        arready,
    output logic [31:0] araddr,
    output logic [3:0]  arid,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    input  logic        rvalid,
    output logic        rready,
    input  logic [31:0] axi_rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic [3:0]  rid
);

    localparam logic [31:0] PAGE_SIZE = 32'd1 << PAGE_Ls;
    localparam logic [31:0] PAGE_MASK = PAGE_SIZE - 32'd1;

    refill_state_t state_reg;
    logic [8:0]    beat_cnt_reg;
    logic [8:0]    remain_reg;

    logic [31:0] req_addr;
    logic [8:0]  req_len;
    logic [31:0] req_room;
    logic [8:0]  first_len;
    logic [31:0] next_base;
    logic [31:0] next_room;
    logic [8:0]  next_len;

    assign arid    = AXI_ID;
    assign arsize  = AXI_SIZE_4B;
    assign arburst = AXI_BURST_INCR;

    always_comb begin
        req_addr  = addr & ~32'h3;
        req_len   = (rlen == 8'd0) ? 9'd1 : {1'b0, rlen};
        req_room  = page_room(req_addr, PAGE_Ls);
        first_len = (req_room < {23'd0, req_len}) ? req_room[8:0] : req_len;
        // Follow-on bursts always start on the next page boundary.
        next_base = (araddr & ~PAGE_MASK) + PAGE_SIZE;
        next_room = page_room(next_base, PAGE_Ls);
        next_len  = (next_room < {23'd0, remain_reg}) ? next_room[8:0] : remain_reg;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            beat_cnt_reg <= 9'd0;
            remain_reg   <= 9'd0;
            rok          <= 1'b0;
            rdata        <= 32'd0;
            rerr         <= 1'b0;
            busy         <= 1'b0;
            arvalid      <= 1'b0;
            araddr       <= 32'd0;
            arlen        <= 8'd0;
            rready       <= 1'b0;
        end else begin
            rok  <= 1'b0;
            rerr <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (rstart) begin
                        araddr       <= req_addr;
                        arlen        <= 8'(first_len - 9'd1);
                        beat_cnt_reg <= first_len;
                        remain_reg   <= req_len - first_len;
                        arvalid      <= 1'b1;
                        busy         <= 1'b1;
                        state_reg    <= ADDR;
                    end
                end
                ADDR: begin
                    if (arready) begin
                        arvalid   <= 1'b0;
                        rready    <= 1'b1;
                        state_reg <= DATA;
                    end
                end
                DATA: begin
                    if (rvalid && rready) begin
                        rdata        <= axi_rdata;
                        rok          <= 1'b1;
                        rerr         <= (rresp == RESP_SLVERR) || (rresp == RESP_DECERR);
                        beat_cnt_reg <= beat_cnt_reg - 9'd1;
                        if (beat_cnt_reg == 9'd1) begin
                            rready <= 1'b0;
                            if (remain_reg != 9'd0) begin
                                araddr       <= next_base;
                                arlen        <= 8'(next_len - 9'd1);
                                beat_cnt_reg <= next_len;
                                remain_reg   <= remain_reg - next_len;
                                arvalid      <= 1'b1;
                                state_reg    <= ADDR;
                            end else begin
                                busy      <= 1'b0;
                                state_reg <= IDLE;
                            end
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Protocol sanity checks on the memory side; they never affect control.
    rid_matches_axi_id: assert property (@(posedge clock) disable iff (!reset)
        (rvalid && rready) |-> (rid == AXI_ID));
    rlast_on_final_beat: assert property (@(posedge clock) disable iff (!reset)
        (rvalid && rready) |-> (rlast == (beat_cnt_reg == 9'd1)));

endmodule

// File: tb/tb_ysyx_25040111_refill_bridge.sv
// Self-checking bench: behavioural AXI slave plus a burst-list reference model
// built from the page-split rule; each rok is checked against a data queue.
module tb_ysyx_25040111_refill_bridge;

    logic        clock;
    logic        reset;
    logic        rstart;
    logic [31:0] addr;
    logic [7:0]  rlen;
    logic        rok;
    logic [31:0] rdata;
    logic        rerr;
    logic        busy;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rvalid;
    logic        rready;
    logic [31:0] axi_rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic [3:0]  rid;

    int compared   = 0;
    int mismatched = 0;

    ysyx_25040111_refill_bridge dut (
        .clock     (clock),
        .reset     (reset),
        .rstart    (rstart),
        .addr      (addr),
        .rlen      (rlen),
        .rok       (rok),
        .rdata     (rdata),
        .rerr      (rerr),
        .busy      (busy),
        .arvalid   (arvalid),
        .arready   (arready),
        .araddr    (araddr),
        .arid      (arid),
        .arlen     (arlen),
        .arsize    (arsize),
        .arburst   (arburst),
        .rvalid    (rvalid),
        .rready    (rready),
        .axi_rdata (axi_rdata),
        .rresp     (rresp),
        .rlast     (rlast),
        .rid       (rid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rok"}, 32'(rok), 32'd0);
        chk({tag, "_rdata"}, rdata, 32'd0);
        chk({tag, "_rerr"}, 32'(rerr), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_arvalid"}, 32'(arvalid), 32'd0);
        chk({tag, "_rready"}, 32'(rready), 32'd0);
        chk({tag, "_araddr"}, araddr, 32'd0);
        chk({tag, "_arlen"}, 32'(arlen), 32'd0);
    endtask

    // One complete refill: model the expected bursts, act as the AXI slave, check everything.
    task automatic do_refill(input logic [31:0] a, input logic [7:0] len, input int ar_wait,
                             input int gap_min, input int gap_max, input int err_idx,
                             input bit rand_resp, input bit second_req, input int lat_exp);
        logic [31:0] b_addr[$];
        int          b_len[$];
        logic [31:0] exp_data[$];
        logic        exp_err[$];
        logic [31:0] cur;
        logic [31:0] d;
        logic [1:0]  resp;
        int left, room, b, total, got, ar_hs, ar_cnt, beats_left, gap_cnt, beat_idx;
        bit done;

        cur   = a & ~32'h3;
        left  = (len == 8'd0) ? 1 : int'(len);
        total = left;
        while (left > 0) begin
            room = int'((32'd4096 - (cur % 32'd4096)) / 32'd4);
            b    = (left < room) ? left : room;
            b_addr.push_back(cur);
            b_len.push_back(b);
            cur  = cur + 32'(4 * b);
            left = left - b;
        end

        @(negedge clock);
        chk("busy_before_start", 32'(busy), 32'd0);
        rstart = 1'b1;
        addr   = a;
        rlen   = len;
        got = 0; ar_hs = 0; ar_cnt = 0; beats_left = 0; gap_cnt = 0; beat_idx = 0; done = 0;

        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            @(negedge clock);
            rstart = 1'b0;
            if (rok) begin
                if (exp_data.size() == 0) begin
                    chk("rok_unexpected", 32'd1, 32'd0);
                end else begin
                    if (got == 0 && lat_exp > 0) chk("first_rok_latency", 32'(cyc), 32'(lat_exp));
                    chk("rdata", rdata, exp_data.pop_front());
                    chk("rerr", 32'(rerr), 32'(exp_err.pop_front()));
                    got++;
                end
            end
            chk("busy", 32'(busy), 32'(got < total));
            done = (got == total);

            arready = 1'b0;
            if (arvalid) begin
                if (ar_hs >= b_addr.size()) begin
                    chk("extra_ar", 32'd1, 32'd0);
                end else begin
                    chk("araddr", araddr, b_addr[ar_hs]);
                    chk("arlen", 32'(arlen), 32'(b_len[ar_hs] - 1));
                    chk("arid", 32'(arid), 32'd0);
                    chk("arsize_arburst", {27'd0, arsize, arburst}, {27'd0, 3'b010, 2'b01});
                    ar_cnt++;
                    if (ar_cnt > ar_wait) begin
                        arready    = 1'b1;
                        beats_left = b_len[ar_hs];
                        ar_hs++;
                        ar_cnt     = 0;
                    end
                end
            end

            rvalid = 1'b0;
            rlast  = 1'b0;
            if (beats_left > 0 && rready) begin
                if (gap_cnt > 0) begin
                    gap_cnt--;
                end else begin
                    d = $urandom;
                    resp = rand_resp ? 2'($urandom_range(0, 3)) : ((beat_idx == err_idx) ? 2'b10 : 2'b00);
                    rvalid    = 1'b1;
                    axi_rdata = d;
                    rresp     = resp;
                    rlast     = (beats_left == 1);
                    rid       = 4'h0;
                    exp_data.push_back(d);
                    exp_err.push_back(resp[1]);
                    beats_left--;
                    beat_idx++;
                    gap_cnt = $urandom_range(gap_max, gap_min);
                end
            end

            if (second_req && cyc == 3 && !done) begin
                rstart = 1'b1;
                addr   = $urandom;
                rlen   = 8'($urandom_range(1, 255));
            end
        end
        if (!done) chk("refill_timeout", 32'(got), 32'(total));

        arready = 1'b0;
        rvalid  = 1'b0;
        rlast   = 1'b0;
        rstart  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("idle_arvalid", 32'(arvalid), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_rok", 32'(rok), 32'd0);
        end
        chk("ar_handshakes", 32'(ar_hs), 32'(b_addr.size()));
    endtask

    initial begin
        logic [31:0] ra;
        reset = 1'b0; rstart = 1'b0; addr = 32'd0; rlen = 8'd0; arready = 1'b0;
        rvalid = 1'b0; axi_rdata = 32'd0; rresp = 2'b00; rlast = 1'b0; rid = 4'h0;

        repeat (3) @(negedge clock);
        chk_reset_outputs("reset");
        reset = 1'b1;

        // 1: single beat, minimum latency
        do_refill(32'h8000_0010, 8'd1, 0, 0, 0, -1, 1'b0, 1'b0, 2);
        // 2: four beats, two idle cycles between beats
        do_refill(32'h8000_0100, 8'd4, 0, 2, 2, -1, 1'b0, 1'b0, 0);
        // 3: page split into 2 + 2 beats
        do_refill(32'h8000_0FF8, 8'd4, 0, 0, 1, -1, 1'b0, 1'b0, 0);
        // 4: arready withheld for 5 cycles
        do_refill(32'h8000_2040, 8'd3, 5, 0, 0, -1, 1'b0, 1'b0, 0);
        // 5: second beat answers SLVERR
        do_refill(32'h8000_3000, 8'd2, 0, 0, 0, 1, 1'b0, 1'b0, 0);

        // 6: asynchronous reset in DATA, just after a beat was captured
        @(negedge clock);
        rstart = 1'b1; addr = 32'h8000_4000; rlen = 8'd8; arready = 1'b1;
        @(negedge clock);
        rstart = 1'b0;
        @(negedge clock);
        arready = 1'b0;
        chk("rst_pre_rready", 32'(rready), 32'd1);
        rvalid = 1'b1; axi_rdata = 32'hCAFE_F00D; rresp = 2'b10; rlast = 1'b0;
        @(posedge clock);
        #2;
        reset  = 1'b0;
        rvalid = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        @(negedge clock);
        reset = 1'b1;
        do_refill(32'h8000_5004, 8'd5, 1, 0, 1, -1, 1'b0, 1'b0, 0);

        // 7: rlen=0 is one beat; 8: rstart while busy is ignored
        do_refill(32'h8000_6000, 8'd0, 0, 0, 0, -1, 1'b0, 1'b0, 2);
        do_refill(32'h8000_7000, 8'd6, 0, 1, 1, -1, 1'b0, 1'b1, 0);

        // Randomized requests, biased toward page ends to exercise splitting
        for (int t = 0; t < 24; t++) begin
            ra = $urandom;
            if ($urandom_range(0, 1) == 1) ra[11:0] = 12'hFFF - 12'($urandom_range(0, 160));
            do_refill(ra, 8'($urandom_range(0, 80)), $urandom_range(0, 3), 0,
                      $urandom_range(0, 2), -1, 1'b1, 1'($urandom_range(0, 1)), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
